// File: rtl/spike_window_classifier_if.sv
// ============================================================================
// Module      : spike_window_classifier_if
// Description : Timestep, window-control and result handshake bundle for the
//               spike window classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spike_window_classifier_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                 enable;
    logic [N-1:0]         output_spikes;
    logic [WIN_W-1:0]     window_len;
    logic                 start;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic [IDX_W-1:0]     winner;
    logic [CNT_W-1:0]     winner_count;
    logic                 tie;
    logic                 saturated;
    logic [N*CNT_W-1:0]   counts_out;

    modport master (
        output enable, output_spikes, window_len, start, result_ready,
        input  busy, result_valid, winner, winner_count, tie, saturated, counts_out
    );

    modport slave (
        input  enable, output_spikes, window_len, start, result_ready,
        output busy, result_valid, winner, winner_count, tie, saturated, counts_out
    );
endinterface

`default_nettype wire

// File: rtl/spike_window_classifier.sv
// ============================================================================
// Module      : spike_window_classifier
// Description : Counts per-neuron spikes over a window of enabled timesteps,
//               then reports the argmax neuron on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_window_classifier #(
    parameter int N     = 2,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    spike_window_classifier_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_W-1:0]     r_cnt [N];
    logic [CNT_W-1:0]     w_cnt_next [N];
    logic [WIN_W-1:0]     r_step;
    logic [WIN_W-1:0]     w_step_limit;
    logic                 r_sat;
    logic                 w_sat_hit;
    logic [N*CNT_W-1:0]   r_counts_out;
    logic [N*CNT_W-1:0]   w_counts_packed;
    logic [IDX_W-1:0]     r_winner;
    logic [IDX_W-1:0]     w_best_idx;
    logic [CNT_W-1:0]     r_winner_count;
    logic [CNT_W-1:0]     w_best_cnt;
    logic                 r_tie;
    logic                 w_tie;
    logic                 w_last;
    logic                 w_clear;
    logic                 w_count_en;
    logic                 w_busy;
    logic                 w_valid;

    // A window length of zero behaves as a single-step window.
    assign w_step_limit = (bus.window_len == '0) ? '0 : bus.window_len - 1'b1;
    assign w_last       = w_count_en && (r_step == w_step_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_COUNT;
            S_COUNT:  if (w_last) w_state_next = S_REPORT;
            S_REPORT: if (bus.result_ready) w_state_next = bus.start ? S_COUNT : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b0;
        w_valid    = 1'b0;
        w_clear    = 1'b0;
        w_count_en = 1'b0;
        case (r_state)
            S_IDLE:   w_clear = bus.start;
            S_COUNT: begin
                w_busy     = 1'b1;
                w_count_en = bus.enable;
            end
            S_REPORT: begin
                w_valid = 1'b1;
                w_clear = bus.result_ready && bus.start;
            end
            default: ;
        endcase
    end

    // Counts including the current sample, so the last step lands in the result.
    always_comb begin
        w_sat_hit       = 1'b0;
        w_counts_packed = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_next[i] = (bus.output_spikes[i] && (r_cnt[i] != C_CNT_MAX)) ?
                            r_cnt[i] + 1'b1 : r_cnt[i];
            w_sat_hit     = w_sat_hit | (w_cnt_next[i] == C_CNT_MAX);
            w_counts_packed[i*CNT_W +: CNT_W] = w_cnt_next[i];
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_idx = '0;
        w_best_cnt = w_cnt_next[0];
        w_tie      = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (w_cnt_next[i] > w_best_cnt) begin
                w_best_idx = IDX_W'(i);
                w_best_cnt = w_cnt_next[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if ((w_cnt_next[i] == w_best_cnt) && (IDX_W'(i) != w_best_idx)) begin
                w_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
            r_step         <= '0;
            r_sat          <= 1'b0;
            r_counts_out   <= '0;
            r_winner       <= '0;
            r_winner_count <= '0;
            r_tie          <= 1'b0;
        end else begin
            if (w_clear) begin
                for (int i = 0; i < N; i++) r_cnt[i] <= '0;
                r_step <= '0;
                r_sat  <= 1'b0;
            end else if (w_count_en) begin
                for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_next[i];
                r_step <= r_step + 1'b1;
                r_sat  <= r_sat | w_sat_hit;
            end
            if (w_last) begin
                r_counts_out   <= w_counts_packed;
                r_winner       <= w_best_idx;
                r_winner_count <= w_best_cnt;
                r_tie          <= w_tie;
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.result_valid = w_valid;
    assign bus.winner       = r_winner;
    assign bus.winner_count = r_winner_count;
    assign bus.tie          = r_tie;
    assign bus.saturated    = r_sat;
    assign bus.counts_out   = r_counts_out;

endmodule

`default_nettype wire

// File: tb/tb_spike_window_classifier.sv
// ============================================================================
// Module      : tb_spike_window_classifier
// Description : Directed self-checking bench for spike_window_classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_window_classifier;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spike_window_classifier_if #(.N(2), .CNT_W(8), .WIN_W(8)) bus8 ();
    spike_window_classifier_if #(.N(2), .CNT_W(4), .WIN_W(8)) bus4 ();

    spike_window_classifier #(.N(2), .CNT_W(8), .WIN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    spike_window_classifier #(.N(2), .CNT_W(4), .WIN_W(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] spk, input logic en, input int n);
        for (int k = 0; k < n; k++) begin
            bus8.output_spikes = spk;
            bus8.enable        = en;
            tick();
        end
    endtask

    task automatic start_window(input logic [7:0] len);
        bus8.window_len = len;
        bus8.enable     = 1'b0;
        bus8.start      = 1'b1;
        tick();
        bus8.start      = 1'b0;
    endtask

    task automatic accept();
        bus8.result_ready = 1'b1;
        tick();
        bus8.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus8.busy, bus8.result_valid, bus8.tie, bus8.saturated} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus8.busy, bus8.result_valid, bus8.tie, bus8.saturated});
        end
        checks++;
        if ({bus8.counts_out, bus8.winner, bus8.winner_count} !== 25'd0) begin
            failures++;
            $display("FAIL reset_result got counts=%h winner=%0d wc=%0d exp all zero",
                     bus8.counts_out, bus8.winner, bus8.winner_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_neuron();
        start_window(8'd10);
        checks++;
        if (bus8.busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_busy got=%b exp=1", bus8.busy);
        end
        drive(2'b01, 1'b1, 9);
        checks++;
        if (bus8.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_early_valid got=%b exp=0", bus8.result_valid);
        end
        drive(2'b01, 1'b1, 1);
        checks++;
        if ({bus8.result_valid, bus8.busy} !== 2'b10) begin
            failures++;
            $display("FAIL t1_valid got=%b exp=10", {bus8.result_valid, bus8.busy});
        end
        checks++;
        if (bus8.counts_out !== 16'h000A || bus8.winner !== 1'b0 ||
            bus8.winner_count !== 8'd10 || bus8.tie !== 1'b0 || bus8.saturated !== 1'b0) begin
            failures++;
            $display("FAIL t1_result got counts=%h w=%0d wc=%0d tie=%b sat=%b exp 000a 0 10 0 0",
                     bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie, bus8.saturated);
        end
        accept();
        checks++;
        if ({bus8.result_valid, bus8.busy} !== 2'b00) begin
            failures++;
            $display("FAIL t1_accept got=%b exp=00", {bus8.result_valid, bus8.busy});
        end
    endtask

    task automatic test_mixed();
        start_window(8'd8);
        drive(2'b10, 1'b1, 3);
        drive(2'b11, 1'b1, 3);
        drive(2'b00, 1'b1, 1);
        checks++;
        if (bus8.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t2_early_valid got=%b exp=0", bus8.result_valid);
        end
        drive(2'b00, 1'b1, 1);
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h0603 || bus8.winner !== 1'b1 ||
            bus8.winner_count !== 8'd6 || bus8.tie !== 1'b0) begin
            failures++;
            $display("FAIL t2_result got v=%b counts=%h w=%0d wc=%0d tie=%b exp 1 0603 1 6 0",
                     bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie);
        end
        accept();
    endtask

    task automatic test_ties();
        start_window(8'd8);
        drive(2'b11, 1'b1, 4);
        drive(2'b00, 1'b1, 4);
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h0404 || bus8.winner !== 1'b0 ||
            bus8.winner_count !== 8'd4 || bus8.tie !== 1'b1) begin
            failures++;
            $display("FAIL t3_equal got v=%b counts=%h w=%0d wc=%0d tie=%b exp 1 0404 0 4 1",
                     bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie);
        end
        accept();
        // Zero length acts as a one-step window.
        start_window(8'd0);
        drive(2'b00, 1'b1, 1);
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h0000 || bus8.winner !== 1'b0 ||
            bus8.winner_count !== 8'd0 || bus8.tie !== 1'b1) begin
            failures++;
            $display("FAIL t3_zero got v=%b counts=%h w=%0d wc=%0d tie=%b exp 1 0000 0 0 1",
                     bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie);
        end
        accept();
    endtask

    task automatic test_saturation();
        bus4.window_len    = 8'd20;
        bus4.start         = 1'b1;
        tick();
        bus4.start         = 1'b0;
        bus4.output_spikes = 2'b11;
        bus4.enable        = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        checks++;
        if (bus4.saturated !== 1'b0) begin
            failures++;
            $display("FAIL t4_sat_early got=%b exp=0", bus4.saturated);
        end
        tick();
        checks++;
        if (bus4.saturated !== 1'b1) begin
            failures++;
            $display("FAIL t4_sat_hit got=%b exp=1", bus4.saturated);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (bus4.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t4_early_valid got=%b exp=0", bus4.result_valid);
        end
        tick();
        checks++;
        if (bus4.result_valid !== 1'b1 || bus4.counts_out !== 8'hFF || bus4.winner !== 1'b0 ||
            bus4.winner_count !== 4'd15 || bus4.tie !== 1'b1 || bus4.saturated !== 1'b1) begin
            failures++;
            $display("FAIL t4_result got v=%b counts=%h w=%0d wc=%0d tie=%b sat=%b exp 1 ff 0 15 1 1",
                     bus4.result_valid, bus4.counts_out, bus4.winner, bus4.winner_count,
                     bus4.tie, bus4.saturated);
        end
        bus4.enable       = 1'b0;
        bus4.result_ready = 1'b1;
        tick();
        bus4.result_ready = 1'b0;
    endtask

    task automatic test_enable_gap();
        start_window(8'd10);
        drive(2'b01, 1'b1, 4);
        drive(2'b11, 1'b0, 5);
        checks++;
        if (bus8.busy !== 1'b1 || bus8.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t5_gap_busy got=%b exp=10", {bus8.busy, bus8.result_valid});
        end
        drive(2'b01, 1'b1, 5);
        checks++;
        if (bus8.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t5_early_valid got=%b exp=0", bus8.result_valid);
        end
        drive(2'b01, 1'b1, 1);
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h000A || bus8.winner_count !== 8'd10) begin
            failures++;
            $display("FAIL t5_result got v=%b counts=%h wc=%0d exp 1 000a 10",
                     bus8.result_valid, bus8.counts_out, bus8.winner_count);
        end
    endtask

    task automatic test_hold();
        // Left in REPORT by the previous test; start without ready must do nothing.
        bus8.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus8.output_spikes = k[1:0];
            bus8.enable        = k[0];
            tick();
            checks++;
            if ({bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie} !==
                {1'b1, 16'h000A, 1'b0, 8'd10, 1'b0}) begin
                failures++;
                $display("FAIL t6_hold cycle=%0d got v=%b counts=%h w=%0d wc=%0d tie=%b exp 1 000a 0 10 0",
                         k, bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus8.window_len   = 8'd3;
        bus8.enable       = 1'b0;
        bus8.result_ready = 1'b1;
        bus8.start        = 1'b1;
        tick();
        bus8.result_ready = 1'b0;
        checks++;
        if ({bus8.busy, bus8.result_valid} !== 2'b10) begin
            failures++;
            $display("FAIL t6_b2b_busy got=%b exp=10", {bus8.busy, bus8.result_valid});
        end
        drive(2'b10, 1'b1, 2);
        checks++;
        if (bus8.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL t6_b2b_early got=%b exp=0", bus8.result_valid);
        end
        drive(2'b10, 1'b1, 1);
        bus8.start = 1'b0;
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h0300 || bus8.winner !== 1'b1 ||
            bus8.winner_count !== 8'd3 || bus8.tie !== 1'b0) begin
            failures++;
            $display("FAIL t6_b2b_result got v=%b counts=%h w=%0d wc=%0d tie=%b exp 1 0300 1 3 0",
                     bus8.result_valid, bus8.counts_out, bus8.winner, bus8.winner_count, bus8.tie);
        end
        accept();
    endtask

    task automatic test_reset_abort();
        start_window(8'd10);
        drive(2'b01, 1'b1, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus8.busy, bus8.result_valid} !== 2'b00 || bus8.counts_out !== 16'h0000 ||
            bus8.winner !== 1'b0 || bus8.winner_count !== 8'd0) begin
            failures++;
            $display("FAIL t6_abort got b/v=%b counts=%h w=%0d wc=%0d exp 00 0000 0 0",
                     {bus8.busy, bus8.result_valid}, bus8.counts_out, bus8.winner, bus8.winner_count);
        end
        for (int k = 0; k < 15; k++) begin
            drive(2'b01, 1'b1, 1);
            checks++;
            if ({bus8.busy, bus8.result_valid} !== 2'b00) begin
                failures++;
                $display("FAIL t6_no_result cycle=%0d got=%b exp=00", k, {bus8.busy, bus8.result_valid});
            end
        end
        start_window(8'd2);
        drive(2'b01, 1'b1, 2);
        checks++;
        if (bus8.result_valid !== 1'b1 || bus8.counts_out !== 16'h0002) begin
            failures++;
            $display("FAIL t6_after_abort got v=%b counts=%h exp 1 0002",
                     bus8.result_valid, bus8.counts_out);
        end
        accept();
    endtask

    initial begin
        reset              = 1'b1;
        bus8.enable        = 1'b0;
        bus8.output_spikes = '0;
        bus8.window_len    = '0;
        bus8.start         = 1'b0;
        bus8.result_ready  = 1'b0;
        bus4.enable        = 1'b0;
        bus4.output_spikes = '0;
        bus4.window_len    = '0;
        bus4.start         = 1'b0;
        bus4.result_ready  = 1'b0;

        test_reset();
        test_single_neuron();
        test_mixed();
        test_ties();
        test_saturation();
        test_enable_gap();
        test_hold();
        test_back_to_back();
        test_reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
